// File: rtl/bcd_sevenseg_scan_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner.
//   bcd_digit_t : one packed BCD digit
//   SEG_*       : active-high gfedcba patterns (bit 0 = a ... bit 6 = g)
//   bcd_to_seg  : BCD digit -> active-high segment pattern; codes A-F map to a dash
package bcd_sevenseg_scan_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    function automatic logic [6:0] bcd_to_seg(input bcd_digit_t d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_DASH;   // non-BCD code: visible error indication
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_sevenseg_scan_tick.sv
// Refresh prescaler and digit-slot counter for the seven-segment scanner.
//   clk, rst   : clock, synchronous active-low reset
//   cnt_zero   : prescaler is at the first cycle of a digit slot
//   wrap       : this cycle is the last cycle of the last slot (idx returns to 0 on the next edge)
//   idx        : digit slot currently being driven
module seg_refresh_tick #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    localparam int CW = $clog2(REFRESH_DIV),
    localparam int IW = $clog2(NUM_DIGITS)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          cnt_zero,
    output logic          wrap,
    output logic [IW-1:0] idx
);

    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [CW-1:0] cnt;
    logic          tc;

    // Comparisons use >= so any out-of-range value falls straight back into range.
    assign tc       = (cnt >= CNT_LAST);
    assign wrap     = tc && (idx >= IDX_LAST);
    assign cnt_zero = (cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (tc) begin
            cnt <= '0;
            idx <= (idx >= IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bcd_sevenseg_scan.sv
// Multiplexed seven-segment display driver.
// Digits written via load land in a pending register; the displayed copy is
// refreshed only when the scan wraps to digit 0, so a frame never tears.
// Each digit slot starts with one dead cycle (all anodes off) to stop ghosting.
//   clk, rst    : clock, synchronous active-low reset
//   bcd_in      : packed BCD digits, [3:0] = least significant digit
//   dp_in       : decimal point request per digit
//   load        : capture bcd_in/dp_in into the pending register
//   seg         : shared segment bus, seg[0]=a .. seg[6]=g
//   dp          : decimal point of the active digit
//   an          : one-hot digit enable
//   frame_done  : one-cycle pulse when the scan returns to digit 0
module bcd_sevenseg_scan
    import bcd_sevenseg_scan_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int BLANK_LZ       = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int IW = $clog2(NUM_DIGITS);

    // Idle (off) levels after polarity is applied.
    localparam logic [6:0]            SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_IDLE  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_IDLE  = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                      : {NUM_DIGITS{1'b0}};

    bcd_digit_t [NUM_DIGITS-1:0] pend_bcd, disp_bcd;
    logic       [NUM_DIGITS-1:0] pend_dp,  disp_dp;

    logic          cnt_zero;
    logic          wrap;
    logic [IW-1:0] idx;

    seg_refresh_tick #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .cnt_zero (cnt_zero),
        .wrap     (wrap),
        .idx      (idx)
    );

    // lz[k]: digit k and every digit above it are zero in the displayed copy.
    logic [NUM_DIGITS-1:0] lz;
    logic                  lz_run;

    always_comb begin
        lz     = '0;
        lz_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            lz_run = lz_run && (disp_bcd[k] == 4'd0);
            lz[k]  = lz_run;
        end
    end

    // Digit select by comparison rather than indexing, so an idx outside
    // 0..NUM_DIGITS-1 simply selects nothing and leaves the anodes off.
    bcd_digit_t            cur_digit;
    logic                  cur_dp;
    logic                  cur_blank;
    logic                  idx_ok;
    logic [NUM_DIGITS-1:0] an_hot;

    always_comb begin
        cur_digit = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        idx_ok    = 1'b0;
        an_hot    = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_digit = disp_bcd[k];
                cur_dp    = disp_dp[k];
                cur_blank = (BLANK_LZ != 0) && (k != 0) && lz[k];
                idx_ok    = 1'b1;
                an_hot[k] = 1'b1;
            end
        end
    end

    logic [6:0] seg_nxt;
    logic       show;

    assign seg_nxt = cur_blank ? SEG_OFF : bcd_to_seg(cur_digit);
    assign show    = !cnt_zero && idx_ok;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_bcd   <= '0;
            pend_dp    <= '0;
            disp_bcd   <= '0;
            disp_dp    <= '0;
            frame_done <= 1'b0;
            an         <= AN_IDLE;
            seg        <= SEG_IDLE;
            dp         <= DP_IDLE;
        end else begin
            if (load) begin
                pend_bcd <= bcd_in;
                pend_dp  <= dp_in;
            end
            // A load on the wrap edge reaches pending only; display takes the old pending.
            if (wrap) begin
                disp_bcd <= pend_bcd;
                disp_dp  <= pend_dp;
            end
            frame_done <= wrap;

            if (show) begin
                an  <= (AN_ACTIVE_LOW  != 0) ? ~an_hot  : an_hot;
                seg <= (SEG_ACTIVE_LOW != 0) ? ~seg_nxt : seg_nxt;
                dp  <= (SEG_ACTIVE_LOW != 0) ? ~cur_dp  : cur_dp;
            end else begin
                an  <= AN_IDLE;
                seg <= SEG_IDLE;
                dp  <= DP_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// Directed bench for bcd_sevenseg_scan (4 digits, 4 clk per slot, active-low outputs).
module tb_bcd_sevenseg_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] bcd_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    bcd_sevenseg_scan #(
        .NUM_DIGITS     (4),
        .REFRESH_DIV    (4),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1),
        .BLANK_LZ       (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .load       (load),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Advance until frame_done is seen, bounded.
    task automatic wait_frame(input string name);
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL %s frame_done timeout got %b want 1", name, frame_done);
        end
    endtask

    // Entered at the negedge just after a wrap edge. Checks all 16 cycles of the
    // frame (dead cycle + 3 lit cycles per digit) and optionally issues a load
    // at cycle ld_c (captured on the following edge).
    task automatic check_frame(input logic [3:0][6:0] es, input logic [3:0] edp,
                               input int ld_c, input logic [15:0] ld_b,
                               input logic [3:0] ld_dp, input string name);
        int         k;
        int         pos;
        logic       exp_fd;
        logic [3:0] exp_an;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            k      = (c - 1) / 4;
            pos    = (c - 1) % 4;
            exp_fd = (c == 16);
            checks++;
            if (frame_done !== exp_fd) begin
                errors++;
                $display("FAIL %s fd c=%0d got %b want %b", name, c, frame_done, exp_fd);
            end
            if (pos == 0) begin
                checks++;
                if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
                    errors++;
                    $display("FAIL %s dead c=%0d got an=%h seg=%h dp=%b want F 7f 1",
                             name, c, an, seg, dp);
                end
            end else begin
                exp_an = ~(4'b0001 << k);
                checks++;
                if (an !== exp_an || seg !== es[k] || dp !== edp[k]) begin
                    errors++;
                    $display("FAIL %s digit%0d c=%0d got an=%h seg=%h dp=%b want %h %h %b",
                             name, k, c, an, seg, dp, exp_an, es[k], edp[k]);
                end
            end
            load = (c == ld_c);
            if (c == ld_c) begin
                bcd_in = ld_b;
                dp_in  = ld_dp;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold got an=%h seg=%h dp=%b fd=%b want F 7f 1 0",
                     an, seg, dp, frame_done);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (an !== 4'hF || seg !== 7'h7F) begin
            errors++;
            $display("FAIL reset_rel1 got an=%h seg=%h want F 7f", an, seg);
        end
        @(negedge clk);
        checks++;
        if (an !== 4'hE || seg !== 7'h40 || dp !== 1'b1) begin
            errors++;
            $display("FAIL reset_rel2 got an=%h seg=%h dp=%b want E 40 1", an, seg, dp);
        end
    endtask

    task automatic test_digits();
        load   = 1'b1;
        bcd_in = 16'h1239;
        dp_in  = 4'b0000;
        @(negedge clk);
        load = 1'b0;
        wait_frame("first_wrap");
        check_frame({7'h79, 7'h24, 7'h30, 7'h10}, 4'hF, 2, 16'h0005, 4'b0100, "digits");
    endtask

    task automatic test_lz();
        check_frame({7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'b1011, 2, 16'h00A0, 4'b0000, "lz");
    endtask

    task automatic test_dash();
        check_frame({7'h7F, 7'h7F, 7'h3F, 7'h40}, 4'hF, 2, 16'h2222, 4'b0000, "dash");
    endtask

    task automatic test_back_to_back();
        check_frame({4{7'h24}}, 4'hF, 6, 16'h1111, 4'b0000, "tear");
        check_frame({4{7'h79}}, 4'hF, 15, 16'h3333, 4'b0000, "wrap_load");
        check_frame({4{7'h79}}, 4'hF, 0, 16'h0000, 4'b0000, "deferred");
        check_frame({4{7'h30}}, 4'hF, 0, 16'h0000, 4'b0000, "latest");
    endtask

    task automatic test_mid_reset();
        repeat (10) @(negedge clk);   // slot 2, cnt = 2
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got an=%h seg=%h dp=%b fd=%b want F 7f 1 0",
                     an, seg, dp, frame_done);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (an !== 4'hF || seg !== 7'h7F) begin
            errors++;
            $display("FAIL mid_rel1 got an=%h seg=%h want F 7f", an, seg);
        end
        @(negedge clk);
        checks++;
        if (an !== 4'hE || seg !== 7'h40) begin
            errors++;
            $display("FAIL mid_rel2 got an=%h seg=%h want E 40", an, seg);
        end
        wait_frame("mid_wrap");
        check_frame({7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF, 0, 16'h0000, 4'b0000, "after_reset");
    endtask

    initial begin
        test_reset();
        test_digits();
        test_lz();
        test_dash();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
